clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
Parametrised multi-channel clock prescaler and tick generator, the successor to the single free-running LED divider.
- Each channel has its own programmable divide ratio, enable, a single-cycle tick strobe and a 50% square-wave output.
- Ratios load through a valid/ready config port, applied either immediately or glitch-free at the channel's next terminal count.
- Drives board LEDs, display multiplexers and UART/debounce timebases from CLK100MHZ.

Parameters:
N_CH, 4, number of independent channels (1..16)
CNT_W, 32, counter and divide-ratio width
DEFAULT_DIV, 67108864, reset divide ratio for every channel (2^26; sq period 2^27 cycles, about 0.75 Hz at 100 MHz)
SYNC_LOAD, 1, 1 = apply new ratio at next terminal count; 0 = apply on the cycle after the handshake

Ports:
CLK100MHZ  in  1  sole clock
CPU_RESETN  in  1  synchronous reset, active-low
en  in  N_CH  per-channel count enable
sync_clr  in  1  clears all counters and square outputs (phase alignment)
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready at a clock edge
cfg_ch  in  $clog2(N_CH) (min 1)  target channel
cfg_div  in  CNT_W  new divide ratio
tick  out  N_CH  one-cycle strobe every div cycles
sq  out  N_CH  toggles at each tick; period 2*div
pending  out  N_CH  per-channel ratio load outstanding

Behaviour:
- One clock; reset is synchronous and active-low. Clock port is CLK100MHZ, reset port is CPU_RESETN.
- Reset (CPU_RESETN=0 at an edge) sets:
  - cnt=0, div_reg=DEFAULT_DIV, tick=0, sq=0, pending=0 for every channel.
  - Reset aborts any outstanding load.
- Per channel i, at each edge, priority order:
  - reset > sync_clr > load-apply > count.
- Count:
  - If en[i]=1 and cnt==div_reg-1: cnt<=0, tick[i]<=1, sq[i]<=~sq[i].
  - Else if en[i]=1: cnt<=cnt+1, tick[i]<=0.
  - If en[i]=0: cnt, sq hold; tick[i]<=0.
- First tick is registered high after exactly div_reg enabled edges from cnt=0. Tick spacing is div_reg cycles.
- Ratio rules:
  - cfg_div of 0 or 1 is stored as 1. div_reg=1 gives tick high continuously while enabled and sq toggling every cycle.
  - Stored values are CNT_W wide with no truncation.
- cfg_ready is combinational: cfg_ready = ~pending[cfg_ch]. An out-of-range cfg_ch (>=N_CH) gives cfg_ready=1, and the accepted write is dropped.
- Handshake with SYNC_LOAD=1:
  - On accept, the new value goes to shadow[i] and pending[i]<=1.
  - At the next edge where channel i hits terminal count: div_reg<=shadow, cnt<=0, tick and sq behave as a normal terminal count, pending<=0.
  - If en[i]=0 while pending: apply at the next edge with cnt<=0; sq holds and no tick is issued.
- Handshake with SYNC_LOAD=0: on accept, div_reg<=value and cnt<=0 at the same edge. There is no tick that edge, sq holds, and pending is never set.
- Writes to different channels may be accepted on consecutive cycles.
- A write accepted on the same edge as a terminal count (SYNC_LOAD=1) does not apply at that edge; it waits for the next terminal count.
- sync_clr: every cnt<=0, sq<=0, tick<=0. div_reg is unchanged and pending is retained.
- Counter wrap: cnt never exceeds div_reg-1.
  - If a lower div_reg is applied while cnt is above it, this is unreachable because every apply clears cnt.
- Outputs are all registered except cfg_ready.

Decomposition:
- Package clk_div_pkg holds:
  - localparam CNT_W_DEF=32 and DIV_MIN=1
  - typedef logic [CNT_W_DEF-1:0] div_t
  - function clamp_div (0/1 -> 1)
- Sub-module clk_div_ch implements one channel: counter, div_reg, shadow, pending, tick, sq.
  - Top instantiates N_CH copies via generate, decodes cfg_ch into a per-channel load strobe, and muxes cfg_ready.

Test Plan:
- Reset and divide: reset, en=4'b0001, DEFAULT_DIV overridden to 4 → tick[0] high on edges 4, 8, 12; sq[0] = 0→1 at edge 4, →0 at edge 8; other channels static at 0.
- Sync load: div=4, running. At cnt=1, write ch0 div=10 → pending[0]=1 and cfg_ready=0 for ch0. Next tick stays 4 cycles after the previous one, then spacing becomes 10. pending clears at the switching tick.
- Clamp and extremes: cfg_div=0 → tick continuous and sq toggling every cycle. cfg_div=32'hFFFF_FFFF accepted without overflow, cnt counts toward 32'hFFFF_FFFE.
- Enable gating: drop en[1] for 5 cycles mid-count → tick[1] is delayed by exactly 5 cycles and sq[1] holds.
- Simultaneous events: sync_clr on the same edge as a terminal count and a cfg accept → cnt=0, sq=0, tick=0; the load stays pending and applies at the next terminal count.
- Reset mid-operation: CPU_RESETN=0 while pending[2]=1 → pending=0, div_reg=DEFAULT_DIV, all outputs 0. With SYNC_LOAD=0, a write gives an immediate ratio change and pending stays 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock prescaler.
// Ratios below DIV_MIN are clamped so a channel can never stall.
package clk_div_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int DIV_MIN = 1;
    localparam logic [CNT_W_DEF-1:0] DEFAULT_DIV_DEF = 32'd67108864;

    typedef logic [CNT_W_DEF-1:0] div_t;

    function automatic div_t clamp_div(input div_t d);
        return (d > div_t'(DIV_MIN)) ? d : div_t'(DIV_MIN);
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Ratio configuration port. Valid/ready: a write transfers on every clock edge
// where cfg_valid and cfg_ready are both high; the master must hold cfg_ch and
// cfg_div stable while cfg_valid is high and cfg_ready is low.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);

endinterface

// File: rtl/clk_div_ch.sv
// One prescaler channel: counter, active and shadow ratio, tick strobe and
// square output. Priority per edge: reset, sync_clr, ratio apply, count.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF),
    parameter bit               SYNC_LOAD   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             sq,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DIV_FLOOR = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] RST_DIV   = (DEFAULT_DIV > DIV_FLOOR) ? DEFAULT_DIV : DIV_FLOOR;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] div_new;
    logic             at_term;

    assign div_new = (load_div > DIV_FLOOR) ? load_div : DIV_FLOOR;
    assign at_term = (cnt == div_reg - DIV_FLOOR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_reg <= RST_DIV;
            shadow  <= RST_DIV;
            pending <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
        end else begin
            // Counter and outputs
            if (sync_clr) begin
                cnt  <= '0;
                sq   <= 1'b0;
                tick <= 1'b0;
            end else if (!SYNC_LOAD && load) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (SYNC_LOAD && pending && !en) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (en && at_term) begin
                cnt  <= '0;
                tick <= 1'b1;
                sq   <= ~sq;
            end else if (en) begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end else begin
                tick <= 1'b0;
            end

            // Ratio path; an accepted write never coincides with pending=1
            if (SYNC_LOAD) begin
                if (load) begin
                    shadow  <= div_new;
                    pending <= 1'b1;
                end else if (pending && !sync_clr && (!en || at_term)) begin
                    div_reg <= shadow;
                    pending <= 1'b0;
                end
            end else if (load) begin
                div_reg <= div_new;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel prescaler top: decodes the config port into per-channel load
// strobes and replicates the channel N_CH times.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int               N_CH        = 4,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF),
    parameter bit               SYNC_LOAD   = 1'b1
) (
    input  logic            CLK100MHZ,
    input  logic            CPU_RESETN,
    input  logic [N_CH-1:0] en,
    input  logic            sync_clr,
    clk_div_multi_if.slave  cfg,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] sq,
    output logic [N_CH-1:0] pending
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            ready;
    logic [N_CH-1:0] load;

    // Out-of-range channel numbers stay ready and match no load strobe
    always_comb begin
        ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) ready = ~pending[i];
        end
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < N_CH; i++) begin
            load[i] = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(i));
        end
    end

    assign cfg.cfg_ready = ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .SYNC_LOAD   (SYNC_LOAD)
        ) u_ch (
            .clk      (CLK100MHZ),
            .rst_n    (CPU_RESETN),
            .en       (en[g]),
            .sync_clr (sync_clr),
            .load     (load[g]),
            .load_div (cfg.cfg_div),
            .tick     (tick[g]),
            .sq       (sq[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench: a 4-channel deferred-load instance and a 3-channel
// immediate-load instance sharing one clock and reset.
module tb_clk_div_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] en_s;
    logic       sync_clr_s;
    logic [3:0] tick_s, sq_s, pending_s;
    logic [2:0] en_i;
    logic       sync_clr_i;
    logic [2:0] tick_i, sq_i, pending_i;

    int n_total = 0;
    int n_bad   = 0;
    int n;

    clk_div_multi_if #(.N_CH(4), .CNT_W(32)) cfg_s ();
    clk_div_multi_if #(.N_CH(3), .CNT_W(32)) cfg_i ();

    clk_div_multi #(.N_CH(4), .CNT_W(32), .DEFAULT_DIV(32'd4), .SYNC_LOAD(1'b1)) dut_s (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .en        (en_s),
        .sync_clr  (sync_clr_s),
        .cfg       (cfg_s),
        .tick      (tick_s),
        .sq        (sq_s),
        .pending   (pending_s)
    );

    clk_div_multi #(.N_CH(3), .CNT_W(32), .DEFAULT_DIV(32'd4), .SYNC_LOAD(1'b0)) dut_i (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .en        (en_i),
        .sync_clr  (sync_clr_i),
        .cfg       (cfg_i),
        .tick      (tick_i),
        .sq        (sq_i),
        .pending   (pending_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the chosen tick is seen; returns the edge count or -1 on timeout
    task automatic wait_tick(input bit use_i, input int ch, input int limit, output int cnt);
        cnt = -1;
        for (int c = 1; c <= limit; c++) begin
            step();
            if ((use_i ? tick_i[ch] : tick_s[ch]) == 1'b1) begin
                cnt = c;
                break;
            end
        end
    endtask

    task automatic write_s(input logic [1:0] ch, input logic [31:0] d);
        cfg_s.cfg_valid = 1'b1;
        cfg_s.cfg_ch    = ch;
        cfg_s.cfg_div   = d;
    endtask

    initial begin
        logic [11:0] tick_hist, sq_hist;
        logic [3:0]  t4, s4;
        logic        other_bad;
        logic        hold_bad;
        int          tick_cnt;

        rst_n = 1'b0;
        en_s = '0; sync_clr_s = 1'b0;
        en_i = 3'b001; sync_clr_i = 1'b0;
        cfg_s.cfg_valid = 1'b0; cfg_s.cfg_ch = '0; cfg_s.cfg_div = '0;
        cfg_i.cfg_valid = 1'b0; cfg_i.cfg_ch = '0; cfg_i.cfg_div = '0;
        repeat (3) step();

        chk("rst_tick", {60'd0, tick_s}, 64'd0);
        chk("rst_sq", {60'd0, sq_s}, 64'd0);
        chk("rst_pending", {60'd0, pending_s}, 64'd0);
        chk("rst_ready", {63'd0, cfg_s.cfg_ready}, 64'd1);

        // Divide by 4 on channel 0
        rst_n = 1'b1;
        en_s  = 4'b0001;
        other_bad = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            tick_hist[k-1] = tick_s[0];
            sq_hist[k-1]   = sq_s[0];
            if ((tick_s[3:1] | sq_s[3:1]) != 3'b000) other_bad = 1'b1;
        end
        chk("div4_tick", {52'd0, tick_hist}, 64'h888);
        chk("div4_sq", {52'd0, sq_hist}, 64'h878);
        chk("div4_others", {63'd0, other_bad}, 64'd0);

        // Deferred ratio change on channel 0
        step();
        write_s(2'd0, 32'd10);
        chk("sync_ready_before", {63'd0, cfg_s.cfg_ready}, 64'd1);
        step();
        cfg_s.cfg_valid = 1'b0;
        chk("sync_pending", {63'd0, pending_s[0]}, 64'd1);
        chk("sync_ready_busy", {63'd0, cfg_s.cfg_ready}, 64'd0);
        wait_tick(1'b0, 0, 50, n);
        chk("sync_old_spacing", 64'(n), 64'd2);
        chk("sync_pending_clr", {63'd0, pending_s[0]}, 64'd0);
        wait_tick(1'b0, 0, 50, n);
        chk("sync_new_spacing1", 64'(n), 64'd10);
        wait_tick(1'b0, 0, 50, n);
        chk("sync_new_spacing2", 64'(n), 64'd10);

        // Ratio 0 clamps to 1 on disabled channel 3
        write_s(2'd3, 32'd0);
        step();
        cfg_s.cfg_valid = 1'b0;
        chk("clamp_pending", {63'd0, pending_s[3]}, 64'd1);
        step();
        chk("clamp_apply_idle", {63'd0, pending_s[3]}, 64'd0);
        en_s[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            t4[k] = tick_s[3];
            s4[k] = sq_s[3];
        end
        chk("clamp_tick", {60'd0, t4}, 64'hF);
        chk("clamp_sq", {60'd0, s4}, 64'h5);
        en_s[3] = 1'b0;
        step();

        // Maximum ratio
        write_s(2'd3, 32'hFFFF_FFFF);
        step();
        cfg_s.cfg_valid = 1'b0;
        step();
        chk("max_pending", {63'd0, pending_s[3]}, 64'd0);
        en_s[3] = 1'b1;
        tick_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (tick_s[3]) tick_cnt++;
        end
        chk("max_no_tick", 64'(tick_cnt), 64'd0);
        en_s[3] = 1'b0;
        step();

        // Enable gating on channel 1
        en_s[1] = 1'b1;
        step();
        step();
        chk("gate_no_early", {63'd0, tick_s[1]}, 64'd0);
        en_s[1] = 1'b0;
        hold_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (tick_s[1] || sq_s[1]) hold_bad = 1'b1;
        end
        chk("gate_hold", {63'd0, hold_bad}, 64'd0);
        en_s[1] = 1'b1;
        wait_tick(1'b0, 1, 50, n);
        chk("gate_remaining", 64'(n), 64'd2);
        chk("gate_sq", {63'd0, sq_s[1]}, 64'd1);

        // sync_clr coinciding with terminal count and a config accept
        repeat (3) step();
        sync_clr_s = 1'b1;
        write_s(2'd1, 32'd6);
        step();
        sync_clr_s = 1'b0;
        cfg_s.cfg_valid = 1'b0;
        chk("clr_tick", {60'd0, tick_s}, 64'd0);
        chk("clr_sq", {60'd0, sq_s}, 64'd0);
        chk("clr_pending", {60'd0, pending_s}, 64'h2);
        wait_tick(1'b0, 1, 50, n);
        chk("clr_old_spacing", 64'(n), 64'd4);
        chk("clr_pending_done", {63'd0, pending_s[1]}, 64'd0);
        chk("clr_sq_after", {63'd0, sq_s[1]}, 64'd1);
        wait_tick(1'b0, 1, 50, n);
        chk("clr_new_spacing", 64'(n), 64'd6);

        // Reset with a load outstanding on channel 2
        en_s[2] = 1'b1;
        write_s(2'd2, 32'd9);
        step();
        cfg_s.cfg_valid = 1'b0;
        chk("mid_pending", {60'd0, pending_s}, 64'h4);
        rst_n = 1'b0;
        en_s  = 4'b0100;
        step();
        chk("mid_rst_tick", {60'd0, tick_s}, 64'd0);
        chk("mid_rst_sq", {60'd0, sq_s}, 64'd0);
        chk("mid_rst_pending", {60'd0, pending_s}, 64'd0);
        chk("mid_rst_ready", {63'd0, cfg_s.cfg_ready}, 64'd1);
        rst_n = 1'b1;
        wait_tick(1'b0, 2, 50, n);
        chk("mid_rst_default_div", 64'(n), 64'd4);

        // Immediate-load instance
        sync_clr_i = 1'b1;
        step();
        sync_clr_i = 1'b0;
        wait_tick(1'b1, 0, 50, n);
        chk("imm_default", 64'(n), 64'd4);
        chk("imm_sq_first", {63'd0, sq_i[0]}, 64'd1);
        step();
        cfg_i.cfg_valid = 1'b1;
        cfg_i.cfg_ch    = 2'd0;
        cfg_i.cfg_div   = 32'd7;
        chk("imm_ready", {63'd0, cfg_i.cfg_ready}, 64'd1);
        step();
        cfg_i.cfg_valid = 1'b0;
        chk("imm_no_tick", {63'd0, tick_i[0]}, 64'd0);
        chk("imm_sq_hold", {63'd0, sq_i[0]}, 64'd1);
        chk("imm_pending", {61'd0, pending_i}, 64'd0);
        wait_tick(1'b1, 0, 50, n);
        chk("imm_new_spacing", 64'(n), 64'd7);
        chk("imm_sq_toggle", {63'd0, sq_i[0]}, 64'd0);

        // Out-of-range channel is accepted and dropped
        cfg_i.cfg_valid = 1'b1;
        cfg_i.cfg_ch    = 2'd3;
        cfg_i.cfg_div   = 32'd2;
        chk("oor_ready", {63'd0, cfg_i.cfg_ready}, 64'd1);
        step();
        cfg_i.cfg_valid = 1'b0;
        wait_tick(1'b1, 0, 50, n);
        chk("oor_dropped", 64'(n), 64'd6);
        chk("oor_pending", {61'd0, pending_i}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
